// File: rtl/issue_unit_if.sv
// Instruction-queue to issue-unit handshake and decoded instruction fields.
interface issue_unit_if #(
    parameter int OT_W = 6
);
    logic            iq_valid;
    logic            iq_ready;
    logic [31:0]     iq_inst;
    logic [31:0]     iq_pc;
    logic [31:0]     iq_jumppc;
    logic [31:0]     iq_imm;
    logic [OT_W-1:0] iq_ordertype;
    logic [4:0]      iq_rs1;
    logic [4:0]      iq_rs2;
    logic [4:0]      iq_rd;
    logic            iq_use_rs1;
    logic            iq_use_rs2;
    logic            iq_wr_rd;
    logic            iq_is_mem;

    modport master (
        output iq_valid, iq_inst, iq_pc, iq_jumppc, iq_imm,
        output iq_ordertype, iq_rs1, iq_rs2, iq_rd,
        output iq_use_rs1, iq_use_rs2, iq_wr_rd, iq_is_mem,
        input  iq_ready
    );

    modport slave (
        input  iq_valid, iq_inst, iq_pc, iq_jumppc, iq_imm,
        input  iq_ordertype, iq_rs1, iq_rs2, iq_rd,
        input  iq_use_rs1, iq_use_rs2, iq_wr_rd, iq_is_mem,
        output iq_ready
    );
endinterface

// File: rtl/issue_unit.sv
// Issue stage: holds one instruction, renames operands, dispatches to RS/SLB
// and allocates the ROB slot; owns the register-status table.
module issue_unit #(
    parameter int ROB_W = 4,
    parameter int RS_W  = 5,
    parameter int OT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             Clear_flag,
    issue_unit_if.slave      iq,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    input  logic [31:0]      rf_rdata1,
    input  logic [31:0]      rf_rdata2,
    input  logic             rob_full,
    input  logic [ROB_W-1:0] rob_tail,
    output logic             rob_alloc,
    output logic [ROB_W-1:0] rob_qtag1,
    output logic [ROB_W-1:0] rob_qtag2,
    input  logic             rob_qready1,
    input  logic             rob_qready2,
    input  logic [31:0]      rob_qvalue1,
    input  logic [31:0]      rob_qvalue2,
    input  logic             commit_valid,
    input  logic [4:0]       commit_rd,
    input  logic [ROB_W-1:0] commit_tag,
    input  logic [RS_W-1:0]  RS_unbusy_pos,
    input  logic             slb_full,
    output logic             insqueue_to_RS_needchange,
    output logic [RS_W-1:0]  r2,
    output logic             slb_we,
    output logic [31:0]      RS_s_vj_r2_,
    output logic [31:0]      RS_s_vk_r2_,
    output logic [31:0]      RS_s_qj_r2_,
    output logic [31:0]      RS_s_qk_r2_,
    output logic [31:0]      RS_s_inst_r2_,
    output logic [31:0]      RS_s_pc_r2_,
    output logic [31:0]      RS_s_jumppc_r2_,
    output logic [31:0]      RS_s_A_r2_,
    output logic [31:0]      RS_s_reorder_r2_,
    output logic [OT_W-1:0]  RS_s_ordertype_r2_,
    output logic             RS_s_busy_r2_,
    input  logic             RS_to_ROB_needchange,
    input  logic [ROB_W-1:0] b2,
    input  logic [31:0]      RS_to_SLB_value,
    input  logic             ROB_to_RS_needchange,
    input  logic [ROB_W-1:0] b3,
    input  logic [31:0]      ROB_to_RS_value_b3,
    input  logic             SLB_to_RS_needchange,
    input  logic [ROB_W-1:0] b4,
    input  logic [31:0]      SLB_to_RS_loadvalue
);
    typedef enum logic {EMPTY, HELD} state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_inst, r_pc, r_jumppc, r_imm;
    logic [OT_W-1:0]  r_ot;
    logic [4:0]       r_rs1, r_rs2, r_rd;
    logic             r_use1, r_use2, r_wr, r_mem;
    logic [31:0]      r_busy;
    logic [ROB_W-1:0] r_tag [32];

    logic             w_held, w_fire, w_ready, w_slot_ok;
    logic [63:0]      w_op1, w_op2;

    function automatic logic [63:0] resolve(
        input logic             use_r,
        input logic [4:0]       rs,
        input logic [31:0]      rdata,
        input logic             bsy,
        input logic [ROB_W-1:0] t,
        input logic             qrdy,
        input logic [31:0]      qval
    );
        logic [31:0] tz;
        tz = {{(32-ROB_W){1'b0}}, t};
        if (!use_r || rs == 5'd0)                  return {32'd0, 32'hFFFF_FFFF};
        if (!bsy)                                  return {rdata, 32'hFFFF_FFFF};
        if (RS_to_ROB_needchange && b2 == t)       return {RS_to_SLB_value, 32'hFFFF_FFFF};
        if (ROB_to_RS_needchange && b3 == t)       return {ROB_to_RS_value_b3, 32'hFFFF_FFFF};
        if (SLB_to_RS_needchange && b4 == t)       return {SLB_to_RS_loadvalue, 32'hFFFF_FFFF};
        if (qrdy)                                  return {qval, 32'hFFFF_FFFF};
        return {32'd0, tz};
    endfunction

    assign w_held    = (r_state == HELD);
    assign w_slot_ok = r_mem ? !slb_full : (RS_unbusy_pos != {RS_W{1'b1}});
    assign w_fire    = w_held & rdy & !Clear_flag & !rob_full & w_slot_ok;
    assign w_ready   = rdy & !Clear_flag & (!w_held | w_fire);
    assign iq.iq_ready = w_ready;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= EMPTY;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next                    = r_state;
        rob_alloc                 = 1'b0;
        insqueue_to_RS_needchange = 1'b0;
        slb_we                    = 1'b0;
        if (rdy) begin
            if (Clear_flag)                      w_next = EMPTY;
            else if (iq.iq_valid && w_ready)     w_next = HELD;
            else if (w_fire)                     w_next = EMPTY;
        end
        if (w_fire) begin
            rob_alloc                 = 1'b1;
            insqueue_to_RS_needchange = !r_mem;
            slb_we                    = r_mem;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && iq.iq_valid && w_ready) begin
            r_inst   <= iq.iq_inst;
            r_pc     <= iq.iq_pc;
            r_jumppc <= iq.iq_jumppc;
            r_imm    <= iq.iq_imm;
            r_ot     <= iq.iq_ordertype;
            r_rs1    <= iq.iq_rs1;
            r_rs2    <= iq.iq_rs2;
            r_rd     <= iq.iq_rd;
            r_use1   <= iq.iq_use_rs1;
            r_use2   <= iq.iq_use_rs2;
            r_wr     <= iq.iq_wr_rd;
            r_mem    <= iq.iq_is_mem;
        end
    end

    // Fire write comes after the commit clear so it wins on the same rd.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= '0;
            for (int i = 0; i < 32; i++) r_tag[i] <= '0;
        end else if (rdy) begin
            if (Clear_flag) begin
                r_busy <= '0;
            end else begin
                if (commit_valid && commit_rd != 5'd0 &&
                    r_busy[commit_rd] && r_tag[commit_rd] == commit_tag)
                    r_busy[commit_rd] <= 1'b0;
                if (w_fire && r_wr && r_rd != 5'd0) begin
                    r_busy[r_rd] <= 1'b1;
                    r_tag[r_rd]  <= rob_tail;
                end
            end
        end
    end

    assign rf_raddr1 = r_rs1;
    assign rf_raddr2 = r_rs2;
    assign rob_qtag1 = r_tag[r_rs1];
    assign rob_qtag2 = r_tag[r_rs2];

    assign w_op1 = resolve(r_use1, r_rs1, rf_rdata1, r_busy[r_rs1],
                           r_tag[r_rs1], rob_qready1, rob_qvalue1);
    assign w_op2 = resolve(r_use2, r_rs2, rf_rdata2, r_busy[r_rs2],
                           r_tag[r_rs2], rob_qready2, rob_qvalue2);

    assign RS_s_vj_r2_        = w_op1[63:32];
    assign RS_s_qj_r2_        = w_op1[31:0];
    assign RS_s_vk_r2_        = w_op2[63:32];
    assign RS_s_qk_r2_        = w_op2[31:0];
    assign RS_s_inst_r2_      = r_inst;
    assign RS_s_pc_r2_        = r_pc;
    assign RS_s_jumppc_r2_    = r_jumppc;
    assign RS_s_A_r2_         = r_imm;
    assign RS_s_reorder_r2_   = {{(32-ROB_W){1'b0}}, rob_tail};
    assign RS_s_ordertype_r2_ = r_ot;
    assign RS_s_busy_r2_      = w_fire;
    assign r2                 = RS_unbusy_pos;
endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: rename, wake-up snoop, stalls, commit, flush.
module tb_issue_unit;
    logic clk = 1'b0;
    logic rst, rdy, Clear_flag;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rob_full, rob_alloc;
    logic [3:0]  rob_tail, rob_qtag1, rob_qtag2;
    logic        rob_qready1, rob_qready2;
    logic [31:0] rob_qvalue1, rob_qvalue2;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [4:0]  RS_unbusy_pos, r2;
    logic        slb_full, rs_we, slb_we;
    logic [31:0] vj, vk, qj, qk, s_inst, s_pc, s_jpc, s_a, s_reorder;
    logic [5:0]  s_ot;
    logic        s_busy;
    logic        bc2_v, bc3_v, bc4_v;
    logic [3:0]  b2, b3, b4;
    logic [31:0] bc2_d, bc3_d, bc4_d;

    int n_chk = 0;
    int n_err = 0;

    issue_unit_if #(.OT_W(6)) iq ();

    issue_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .Clear_flag(Clear_flag),
        .iq(iq.slave),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rob_full(rob_full), .rob_tail(rob_tail), .rob_alloc(rob_alloc),
        .rob_qtag1(rob_qtag1), .rob_qtag2(rob_qtag2),
        .rob_qready1(rob_qready1), .rob_qready2(rob_qready2),
        .rob_qvalue1(rob_qvalue1), .rob_qvalue2(rob_qvalue2),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_tag(commit_tag),
        .RS_unbusy_pos(RS_unbusy_pos), .slb_full(slb_full),
        .insqueue_to_RS_needchange(rs_we), .r2(r2), .slb_we(slb_we),
        .RS_s_vj_r2_(vj), .RS_s_vk_r2_(vk),
        .RS_s_qj_r2_(qj), .RS_s_qk_r2_(qk),
        .RS_s_inst_r2_(s_inst), .RS_s_pc_r2_(s_pc),
        .RS_s_jumppc_r2_(s_jpc), .RS_s_A_r2_(s_a),
        .RS_s_reorder_r2_(s_reorder), .RS_s_ordertype_r2_(s_ot),
        .RS_s_busy_r2_(s_busy),
        .RS_to_ROB_needchange(bc2_v), .b2(b2), .RS_to_SLB_value(bc2_d),
        .ROB_to_RS_needchange(bc3_v), .b3(b3), .ROB_to_RS_value_b3(bc3_d),
        .SLB_to_RS_needchange(bc4_v), .b4(b4), .SLB_to_RS_loadvalue(bc4_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic mem,
                           input logic [31:0] imm);
        iq.iq_valid     = 1'b1;
        iq.iq_rs1       = rs1;
        iq.iq_rs2       = rs2;
        iq.iq_rd        = rd;
        iq.iq_use_rs1   = 1'b1;
        iq.iq_use_rs2   = !mem;
        iq.iq_wr_rd     = 1'b1;
        iq.iq_is_mem    = mem;
        iq.iq_imm       = imm;
        iq.iq_inst      = {27'd0, rd};
        iq.iq_pc        = 32'h100 + {27'd0, rd};
        iq.iq_jumppc    = 32'h200;
        iq.iq_ordertype = mem ? 6'd20 : 6'd1;
    endtask

    task automatic strobes(input string tag, input logic e_rs,
                           input logic e_slb, input logic e_rdy);
        #1;
        chk({tag, ".rs_we"}, {31'd0, rs_we}, {31'd0, e_rs});
        chk({tag, ".slb_we"}, {31'd0, slb_we}, {31'd0, e_slb});
        chk({tag, ".alloc"}, {31'd0, rob_alloc}, {31'd0, e_rs | e_slb});
        chk({tag, ".ready"}, {31'd0, iq.iq_ready}, {31'd0, e_rdy});
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; Clear_flag = 1'b0;
        rf_rdata1 = 32'd5; rf_rdata2 = 32'd7;
        rob_full = 1'b0; rob_tail = 4'd2;
        rob_qready1 = 1'b0; rob_qready2 = 1'b0;
        rob_qvalue1 = 32'h9999; rob_qvalue2 = 32'h0;
        commit_valid = 1'b0; commit_rd = 5'd0; commit_tag = 4'd0;
        RS_unbusy_pos = 5'd0; slb_full = 1'b0;
        bc2_v = 0; bc3_v = 0; bc4_v = 0;
        b2 = 4'd2; b3 = 4'd2; b4 = 4'd2;
        bc2_d = 32'h1234; bc3_d = 32'h5555; bc4_d = 32'h6666;
        iq.iq_valid = 1'b0;
        present(5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        iq.iq_valid = 1'b0;
        tick(); tick();
        strobes("reset", 1'b0, 1'b0, 1'b1);
        rst = 1'b1;

        present(5'd1, 5'd2, 5'd3, 1'b0, 32'h77);
        tick();
        present(5'd3, 5'd0, 5'd4, 1'b0, 32'h0);
        strobes("add1", 1'b1, 1'b0, 1'b1);
        chk("add1.vj", vj, 32'd5);
        chk("add1.vk", vk, 32'd7);
        chk("add1.qj", qj, 32'hFFFF_FFFF);
        chk("add1.qk", qk, 32'hFFFF_FFFF);
        chk("add1.reorder", s_reorder, 32'd2);
        chk("add1.A", s_a, 32'h77);
        chk("add1.raddr1", {27'd0, rf_raddr1}, 32'd1);
        chk("add1.busy", {31'd0, s_busy}, 32'd1);
        tick();

        iq.iq_valid = 1'b0;
        rob_tail = 4'd3;
        RS_unbusy_pos = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            strobes("rsfull", 1'b0, 1'b0, 1'b0);
            tick();
        end
        RS_unbusy_pos = 5'd9;
        present(5'd3, 5'd0, 5'd5, 1'b0, 32'h0);
        strobes("add2", 1'b1, 1'b0, 1'b1);
        chk("add2.r2", {27'd0, r2}, 32'd9);
        chk("add2.qtag1", {28'd0, rob_qtag1}, 32'd2);
        chk("add2.qj", qj, 32'd2);
        chk("add2.vj", vj, 32'd0);
        chk("add2.vk", vk, 32'd0);
        chk("add2.qk", qk, 32'hFFFF_FFFF);
        chk("add2.reorder", s_reorder, 32'd3);
        tick();

        rob_tail = 4'd4;
        bc2_v = 1; bc3_v = 1; rob_qready1 = 1'b1;
        present(5'd3, 5'd0, 5'd6, 1'b0, 32'h0);
        strobes("bc2", 1'b1, 1'b0, 1'b1);
        chk("bc2.vj", vj, 32'h1234);
        chk("bc2.qj", qj, 32'hFFFF_FFFF);
        tick();

        bc2_v = 0; bc4_v = 1;
        present(5'd3, 5'd0, 5'd7, 1'b0, 32'h0);
        #1;
        chk("bc3.vj", vj, 32'h5555);
        tick();

        bc3_v = 0;
        present(5'd3, 5'd0, 5'd8, 1'b0, 32'h0);
        #1;
        chk("bc4.vj", vj, 32'h6666);
        tick();

        b4 = 4'd7; bc4_d = 32'h7777;
        present(5'd1, 5'd0, 5'd9, 1'b1, 32'h10);
        #1;
        chk("qrdy.vj", vj, 32'h9999);
        chk("qrdy.qj", qj, 32'hFFFF_FFFF);
        tick();

        bc4_v = 0; rob_qready1 = 1'b0;
        iq.iq_valid = 1'b0;
        slb_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            strobes("slbfull", 1'b0, 1'b0, 1'b0);
            tick();
        end
        slb_full = 1'b0;
        present(5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
        strobes("load", 1'b0, 1'b1, 1'b1);
        chk("load.vj", vj, 32'd5);
        chk("load.A", s_a, 32'h10);
        chk("load.ot", {26'd0, s_ot}, 32'd20);
        tick();

        rob_tail = 4'd5;
        commit_valid = 1'b1; commit_rd = 5'd3; commit_tag = 4'd2;
        present(5'd3, 5'd0, 5'd10, 1'b0, 32'h0);
        strobes("cmt", 1'b1, 1'b0, 1'b1);
        tick();

        commit_tag = 4'd5;
        present(5'd3, 5'd0, 5'd11, 1'b0, 32'h0);
        #1;
        chk("cmt.qtag1", {28'd0, rob_qtag1}, 32'd5);
        chk("cmt.qj", qj, 32'd5);
        tick();

        commit_valid = 1'b0;
        rob_tail = 4'd6;
        present(5'd1, 5'd2, 5'd3, 1'b0, 32'h0);
        #1;
        chk("cmt2.qj", qj, 32'hFFFF_FFFF);
        chk("cmt2.vj", vj, 32'd5);
        tick();

        present(5'd3, 5'd0, 5'd12, 1'b0, 32'h0);
        strobes("wrx3", 1'b1, 1'b0, 1'b1);
        tick();

        iq.iq_valid = 1'b0;
        Clear_flag = 1'b1;
        strobes("clr", 1'b0, 1'b0, 1'b0);
        tick();
        Clear_flag = 1'b0;
        strobes("clr.after", 1'b0, 1'b0, 1'b1);
        present(5'd3, 5'd0, 5'd13, 1'b0, 32'h0);
        tick();

        iq.iq_valid = 1'b0;
        rdy = 1'b0;
        strobes("frz", 1'b0, 1'b0, 1'b0);
        tick();
        rdy = 1'b1;
        strobes("post", 1'b1, 1'b0, 1'b1);
        chk("post.vj", vj, 32'd5);
        chk("post.qj", qj, 32'hFFFF_FFFF);
        tick();
        strobes("idle", 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
